// File: rtl/onewire_txn_sequencer.sv
// 1-Wire bus master: runs reset/presence, write-byte and read-byte transactions from single host commands.
// All slot timing comes from one timer counting clk cycles (CLKS_PER_US per microsecond).
module onewire_txn_sequencer #(
    parameter int CLKS_PER_US = 1,
    parameter int T_RSTL      = 480,
    parameter int T_RSTH      = 480,
    parameter int T_PDS       = 70,
    parameter int T_SLOT      = 70,
    parameter int T_LOW1      = 6,
    parameter int T_LOW0      = 60,
    parameter int T_RDS       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_in,
    output logic       bus_pull_low,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       busy
);

    localparam int MAX_US = (T_RSTL > T_RSTH) ? ((T_RSTL > T_SLOT) ? T_RSTL : T_SLOT)
                                              : ((T_RSTH > T_SLOT) ? T_RSTH : T_SLOT);
    localparam int TW     = $clog2(MAX_US * CLKS_PER_US + 1);

    localparam logic [TW-1:0] RSTL_LAST = TW'(T_RSTL * CLKS_PER_US - 1);
    localparam logic [TW-1:0] RSTH_LAST = TW'(T_RSTH * CLKS_PER_US - 1);
    localparam logic [TW-1:0] PDS_AT    = TW'(T_PDS * CLKS_PER_US);
    localparam logic [TW-1:0] SLOT_LAST = TW'(T_SLOT * CLKS_PER_US - 1);
    localparam logic [TW-1:0] LOW1_LAST = TW'(T_LOW1 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] LOW0_LAST = TW'(T_LOW0 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] RDS_AT    = TW'(T_RDS * CLKS_PER_US);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_REL,
        SLOT_LOW,
        SLOT_REL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] low_last;
    logic [2:0]    bit_idx;
    logic [1:0]    op_q;
    logic [7:0]    shift_q;
    logic          presence_q;
    logic [1:0]    bus_sync;
    logic          bus_s;
    logic          accept;

    assign bus_s     = bus_sync[1];
    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;

    // Write-0 slots hold the bus low much longer than write-1 and read slots.
    assign low_last = (op_q == OP_WRITE && !shift_q[bit_idx]) ? LOW0_LAST : LOW1_LAST;

    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        case (state)
            IDLE, DONE: begin
                timer_next = '0;
                state_next = IDLE;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RESET:         state_next = RST_LOW;
                        OP_WRITE, OP_READ: state_next = SLOT_LOW;
                        default:          state_next = DONE;
                    endcase
                end
            end
            RST_LOW: begin
                if (timer == RSTL_LAST) begin
                    state_next = RST_REL;
                    timer_next = '0;
                end
            end
            RST_REL: begin
                if (timer == RSTH_LAST) state_next = DONE;
            end
            SLOT_LOW: begin
                if (timer == low_last) state_next = SLOT_REL;
            end
            SLOT_REL: begin
                if (timer == SLOT_LAST) begin
                    timer_next = '0;
                    state_next = (bit_idx == 3'd7) ? DONE : SLOT_LOW;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // The timer runs straight through SLOT_LOW into SLOT_REL so the read sample point is slot-relative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            op_q         <= '0;
            shift_q      <= '0;
            presence_q   <= 1'b0;
            bus_sync     <= 2'b11;
            bus_pull_low <= 1'b0;
            rsp_data     <= '0;
            rsp_presence <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            bus_sync     <= {bus_sync[0], bus_in};
            bus_pull_low <= (state_next == RST_LOW) || (state_next == SLOT_LOW);

            if (accept) begin
                op_q    <= cmd_op;
                shift_q <= cmd_data;
                bit_idx <= '0;
            end else if (state == SLOT_REL && timer == SLOT_LAST) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if ((state == SLOT_LOW || state == SLOT_REL) && op_q == OP_READ && timer == RDS_AT)
                shift_q[bit_idx] <= bus_s;

            if (state == RST_REL && timer == PDS_AT)
                presence_q <= ~bus_s;

            if (state == RST_REL && state_next == DONE)
                rsp_presence <= (timer == PDS_AT) ? ~bus_s : presence_q;

            if (state == SLOT_REL && state_next == DONE)
                rsp_data <= shift_q;
        end
    end

endmodule

// File: tb/tb_onewire_txn_sequencer.sv
// Randomised bench for onewire_txn_sequencer: a transaction-level timing model predicts every output
// each cycle, and a simple bus device answers reset and read slots.
module tb_onewire_txn_sequencer;

    localparam int T_RSTL = 480;
    localparam int T_RSTH = 480;
    localparam int T_SLOT = 70;
    localparam int T_LOW1 = 6;
    localparam int T_LOW0 = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_in;
    logic       bus_pull_low;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;

    onewire_txn_sequencer #(
        .CLKS_PER_US(1), .T_RSTL(T_RSTL), .T_RSTH(T_RSTH), .T_PDS(70),
        .T_SLOT(T_SLOT), .T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_RDS(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_pull_low(bus_pull_low),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic dev_low = 1'b0;
    assign bus_in = bus_pull_low ? 1'b0 : ~dev_low;

    int checks = 0;
    int errors = 0;

    logic       dev_present;
    logic [7:0] dev_byte;

    bit         m_act = 1'b0;
    int         t_start = 0;
    int         prev_start = 0;
    logic [1:0] m_op;
    logic [7:0] m_data;
    logic [7:0] m_byte;
    logic       m_pres;
    logic [7:0] exp_data = 8'h00;
    logic       exp_pres = 1'b0;

    int  pulse_len[$];
    int  pulse_start[$];
    int  rise_cyc = 0;
    int  rsp_count = 0;
    int  last_rsp_cyc = 0;
    bit  pull_prev = 1'b0;
    int  exp_len[8] = '{6, 60, 6, 60, 60, 6, 60, 6};

    function automatic int op_len(input logic [1:0] op);
        case (op)
            2'd0:       return 1 + T_RSTL + T_RSTH;
            2'd1, 2'd2: return 1 + 8 * T_SLOT;
            default:    return 1;
        endcase
    endfunction

    function automatic bit exp_pull_at(input int d, input logic [1:0] op, input logic [7:0] data);
        int i;
        int off;
        int len;
        if (op == 2'd0) return (d >= 1) && (d <= T_RSTL);
        if (op == 2'd3 || d < 1 || d > 8 * T_SLOT) return 1'b0;
        i   = (d - 1) / T_SLOT;
        off = (d - 1) % T_SLOT;
        len = (op == 2'd1 && !data[i]) ? T_LOW0 : T_LOW1;
        return off < len;
    endfunction

    function automatic bit dev_low_at(input int d, input logic [1:0] op, input logic pres,
                                      input logic [7:0] rbyte);
        int i;
        int off;
        if (op == 2'd0) return pres && (d >= 1 + T_RSTL + 15) && (d < 1 + T_RSTL + 135);
        if (op != 2'd2 || d < 1 || d > 8 * T_SLOT) return 1'b0;
        i   = (d - 1) / T_SLOT;
        off = (d - 1) % T_SLOT;
        return !rbyte[i] && (off >= 6) && (off < 40);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act_v, exp_v, cyc);
        end
    endtask

    // Per-cycle reference comparison and acceptance tracking.
    always @(negedge clk) begin
        int d;
        bit e_pull;
        bit e_busy;
        bit e_valid;
        e_pull  = 1'b0;
        e_busy  = 1'b0;
        e_valid = 1'b0;
        if (!rst_n) begin
            m_act    = 1'b0;
            exp_data = 8'h00;
            exp_pres = 1'b0;
        end
        if (m_act) begin
            d       = cyc - t_start;
            e_busy  = (d >= 1) && (d < op_len(m_op));
            e_valid = (d == op_len(m_op));
            e_pull  = exp_pull_at(d, m_op, m_data);
            if (e_valid) begin
                case (m_op)
                    2'd0:    exp_pres = m_pres;
                    2'd1:    exp_data = m_data;
                    2'd2:    exp_data = m_byte;
                    default: ;
                endcase
            end
        end
        checkOutput("bus_pull_low", {31'd0, bus_pull_low}, {31'd0, e_pull});
        checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, ~e_busy});
        checkOutput("busy", {31'd0, busy}, {31'd0, e_busy});
        checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
        checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
        checkOutput("rsp_presence", {31'd0, rsp_presence}, {31'd0, exp_pres});
        if (m_act && (cyc - t_start) >= op_len(m_op)) m_act = 1'b0;
        if (rst_n && cmd_valid && !e_busy) begin
            prev_start = t_start;
            t_start    = cyc;
            m_act      = 1'b1;
            m_op       = cmd_op;
            m_data     = cmd_data;
            m_byte     = dev_byte;
            m_pres     = dev_present;
        end
    end

    always @(posedge clk) begin
        #1;
        dev_low = m_act && dev_low_at(cyc - t_start, m_op, m_pres, m_byte);
    end

    // Pulse and response recorder for the literal timing checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            pull_prev = 1'b0;
        end else begin
            if (bus_pull_low && !pull_prev) rise_cyc = cyc;
            if (!bus_pull_low && pull_prev) begin
                pulse_len.push_back(cyc - rise_cyc);
                pulse_start.push_back(rise_cyc);
            end
            pull_prev = bus_pull_low;
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
            end
        end
    end

    task automatic clearRec();
        pulse_len.delete();
        pulse_start.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
        int n;
        n         = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (m_act && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (m_act) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no completion within %0d cycles", n);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int rc;
        logic [1:0] rop;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_data    = 8'h00;
        dev_present = 1'b0;
        dev_byte    = 8'h00;
        #1;
        checkOutput("reset_pull", {31'd0, bus_pull_low}, 32'd0);
        checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, rsp_data}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] reset with device present");
        dev_present = 1'b1;
        clearRec();
        applyStimulus(2'd0, 8'h00);
        waitIdle();
        checkOutput("rst_pulse_count", pulse_len.size(), 32'd1);
        if (pulse_len.size() > 0) checkOutput("rst_pulse_len", pulse_len[0], 32'd480);
        checkOutput("rst_latency", last_rsp_cyc - t_start, 32'd961);
        checkOutput("presence_yes", {31'd0, rsp_presence}, 32'd1);

        $display("[TB] reset with no device, then write");
        dev_present = 1'b0;
        applyStimulus(2'd0, 8'h00);
        waitIdle();
        checkOutput("presence_no", {31'd0, rsp_presence}, 32'd0);
        checkOutput("rst_latency_nodev", last_rsp_cyc - t_start, 32'd961);
        applyStimulus(2'd1, 8'h5A);
        waitIdle();
        checkOutput("presence_held", {31'd0, rsp_presence}, 32'd0);

        $display("[TB] write 0xA5");
        clearRec();
        applyStimulus(2'd1, 8'hA5);
        waitIdle();
        checkOutput("wr_pulse_count", pulse_len.size(), 32'd8);
        for (int i = 0; i < 8 && i < pulse_len.size(); i++) begin
            checkOutput("wr_pulse_len", pulse_len[i], exp_len[i]);
            checkOutput("wr_pulse_spacing", pulse_start[i] - pulse_start[0], 70 * i);
        end
        checkOutput("wr_latency", last_rsp_cyc - t_start, 32'd561);
        checkOutput("wr_echo", {24'd0, rsp_data}, 32'hA5);

        $display("[TB] read 0x3C");
        dev_byte = 8'h3C;
        clearRec();
        applyStimulus(2'd2, 8'hFF);
        waitIdle();
        checkOutput("rd_pulse_count", pulse_len.size(), 32'd8);
        for (int i = 0; i < pulse_len.size(); i++)
            checkOutput("rd_pulse_len", pulse_len[i], 32'd6);
        checkOutput("rd_data", {24'd0, rsp_data}, 32'h3C);

        $display("[TB] back-to-back command held while busy");
        applyStimulus(2'd1, 8'h96);
        applyStimulus(2'd3, 8'h11);
        waitIdle();
        checkOutput("b2b_accept_gap", t_start - prev_start, 32'd561);
        checkOutput("nop_keeps_data", {24'd0, rsp_data}, 32'h96);

        $display("[TB] no-op");
        clearRec();
        applyStimulus(2'd3, 8'h22);
        waitIdle();
        checkOutput("nop_latency", last_rsp_cyc - t_start, 32'd1);
        checkOutput("nop_no_pulses", pulse_len.size(), 32'd0);
        checkOutput("nop_data", {24'd0, rsp_data}, 32'h96);

        $display("[TB] reset during slot 3");
        applyStimulus(2'd1, 8'h00);
        while (cyc < t_start + 1 + 3 * T_SLOT + 10) begin
            @(posedge clk);
            #2;
        end
        checkOutput("slot3_low", {31'd0, bus_pull_low}, 32'd1);
        rc    = rsp_count;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_release", {31'd0, bus_pull_low}, 32'd0);
        checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (700) @(posedge clk);
        #2;
        checkOutput("abort_no_rsp", rsp_count, rc);
        checkOutput("abort_data_cleared", {24'd0, rsp_data}, 32'd0);

        $display("[TB] randomised commands");
        for (int k = 0; k < 30; k++) begin
            rop         = 2'($urandom_range(0, 3));
            dev_present = 1'($urandom_range(0, 1));
            dev_byte    = 8'($urandom);
            applyStimulus(rop, 8'($urandom));
            if ($urandom_range(0, 1) == 1) waitIdle();
        end
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
